// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants and helpers for the ZXDOS front-panel I/O conditioner.
// Holds the 50 MHz board defaults, pad polarity constants and a counter-width helper.
package board_io_pkg;

  // 10 ms debounce, 2 Hz blink and 1 s long press at 50 MHz.
  localparam int unsigned DefDbCycles    = 500000;
  localparam int unsigned DefBlinkHalf   = 12500000;
  localparam int unsigned DefLongCycles  = 50000000;

  localparam bit PolActiveLow  = 1'b1;
  localparam bit PolActiveHigh = 1'b0;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_io_debounce.sv
// board_io_debounce: one button channel.
// Two-flop synchroniser, debounce counter with press/release pulses and, when the macro
// BOARD_IO_LONGPRESS_EN is defined, a saturating hold counter producing a long-press pulse.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   pad_i      raw asynchronous button pad
//   level_o    debounced state, 1 = pressed
//   press_o    one-clock pulse on debounced press
//   release_o  one-clock pulse on debounced release
//   long_o     one-clock long-press pulse (0 when the feature is not built)
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DefDbCycles,
  parameter bit          BTN_ACTIVE_LOW = PolActiveLow,
  parameter int unsigned LONG_CYCLES    = DefLongCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CntW = width_of(DB_CYCLES);

  if (DB_CYCLES < 2) begin : g_db_min
    $error("DB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_long_min
    $error("LONG_CYCLES must be at least 2");
  end

  logic            raw;
  logic            sync1_q, sync_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Normalise to 1 = pressed before synchronising.
  assign raw = pad_i ^ BTN_ACTIVE_LOW;

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = cnt_q + 1'b1;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
      level_d   = ~level_q;
      cnt_d     = '0;
      press_d   = ~level_q;
      release_d = level_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Synchronisers start at the released level so a held button needs a full debounce.
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync_q    <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BOARD_IO_LONGPRESS_EN
  localparam int unsigned HoldW = width_of(LONG_CYCLES + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Saturation at LONG_CYCLES guarantees the match below fires once per press.
  always_comb begin
    hold_d = hold_q;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HoldW'(LONG_CYCLES)) begin
      hold_d = hold_q + 1'b1;
    end
    long_d = level_q && (hold_q == HoldW'(LONG_CYCLES - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: front-panel I/O conditioner between the board pads and the system core.
// Per-button synchronise/debounce with press/release pulses, configurable pad polarity,
// per-LED PWM brightness and a shared blink generator. The long-press detector is built
// only when BOARD_IO_LONGPRESS_EN is defined; otherwise BTN_LONG is tied to 0.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   BTN_PAD      raw button pads               -> BTN_LEVEL/PRESS/RELEASE/LONG
//   LED_IN       logical LED request, 1 = on
//   LED_BLINK    gate LED with the blink phase
//   LED_BRIGHT   packed per-LED duty, channel i at [i*PWM_BITS +: PWM_BITS]
//   LED_PAD      registered physical LED drive
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned NBTN           = 2,
  parameter int unsigned NLED           = 2,
  parameter int unsigned DB_CYCLES      = DefDbCycles,
  parameter int unsigned BLINK_HALF     = DefBlinkHalf,
  parameter int unsigned PWM_BITS       = 4,
  parameter bit          BTN_ACTIVE_LOW = PolActiveLow,
  parameter bit          LED_ACTIVE_LOW = PolActiveLow,
  parameter int unsigned LONG_CYCLES    = DefLongCycles
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NBTN-1:0]          BTN_PAD,
  output logic [NBTN-1:0]          BTN_LEVEL,
  output logic [NBTN-1:0]          BTN_PRESS,
  output logic [NBTN-1:0]          BTN_RELEASE,
  output logic [NBTN-1:0]          BTN_LONG,
  input  logic [NLED-1:0]          LED_IN,
  input  logic [NLED-1:0]          LED_BLINK,
  input  logic [NLED*PWM_BITS-1:0] LED_BRIGHT,
  output logic [NLED-1:0]          LED_PAD
);

  localparam int unsigned BlinkW = width_of(BLINK_HALF);

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    board_io_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_debounce (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .pad_i     (BTN_PAD[i]),
      .level_o   (BTN_LEVEL[i]),
      .press_o   (BTN_PRESS[i]),
      .release_o (BTN_RELEASE[i]),
      .long_o    (BTN_LONG[i])
    );
  end

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [NLED-1:0]     led_on;
  logic [NLED-1:0]     led_pad_q, led_pad_d;

  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BlinkW'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Phase 0 is the lit half, so blinking LEDs start on right after reset.
  always_comb begin
    led_on = '0;
    for (int i = 0; i < NLED; i++) begin
      led_on[i] = LED_IN[i]
                  && (pwm_cnt_q <= LED_BRIGHT[i*PWM_BITS +: PWM_BITS])
                  && (!LED_BLINK[i] || !blink_phase_q);
    end
    led_pad_d = led_on ^ {NLED{LED_ACTIVE_LOW}};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_pad_q     <= {NLED{LED_ACTIVE_LOW}};
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_pad_q     <= led_pad_d;
    end
  end

  assign LED_PAD = led_pad_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DB_CYCLES=8, BLINK_HALF=16, PWM_BITS=2,
// LONG_CYCLES=20 and both pad polarities active-low.
module tb_board_io_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] BTN_PAD;
  logic [1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;
  logic [1:0] LED_IN, LED_BLINK, LED_PAD;
  logic [3:0] LED_BRIGHT;

  int n_tests = 0;
  int n_fail  = 0;

  board_io_ctrl #(
    .NBTN           (2),
    .NLED           (2),
    .DB_CYCLES      (8),
    .BLINK_HALF     (16),
    .PWM_BITS       (2),
    .BTN_ACTIVE_LOW (1'b1),
    .LED_ACTIVE_LOW (1'b1),
    .LONG_CYCLES    (20)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BTN_PAD     (BTN_PAD),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG),
    .LED_IN      (LED_IN),
    .LED_BLINK   (LED_BLINK),
    .LED_BRIGHT  (LED_BRIGHT),
    .LED_PAD     (LED_PAD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_btn(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                           input logic [1:0] rel, input logic [1:0] lng);
    check({tag, "_level"}, 32'(BTN_LEVEL), 32'(lvl));
    check({tag, "_press"}, 32'(BTN_PRESS), 32'(prs));
    check({tag, "_release"}, 32'(BTN_RELEASE), 32'(rel));
    check({tag, "_long"}, 32'(BTN_LONG), 32'(lng));
  endtask

  // Sample 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic exp_pad;
    logic [1:0] exp_long;

    // Reset with pads idle (released = high, LEDs off).
    RESET      = 1'b1;
    BTN_PAD    = 2'b11;
    LED_IN     = 2'b00;
    LED_BLINK  = 2'b00;
    LED_BRIGHT = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_led", 32'(LED_PAD), 32'h3);
      check_btn("rst", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    RESET = 1'b0;
    tick();
    check("post_rst_led", 32'(LED_PAD), 32'h3);
    check_btn("post_rst", 2'b00, 2'b00, 2'b00, 2'b00);

    // Bounce: 5 low, 1 high, then low steady; level rises on the 10th edge.
    BTN_PAD = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_btn("bounce_low", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    BTN_PAD = 2'b11;
    tick();
    check_btn("bounce_high", 2'b00, 2'b00, 2'b00, 2'b00);
    BTN_PAD = 2'b10;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_btn("bounce_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    check_btn("bounce_press", 2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    check_btn("bounce_after", 2'b01, 2'b00, 2'b00, 2'b00);

    // Release after 10 edges.
    BTN_PAD = 2'b11;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_btn("rel_wait", 2'b01, 2'b00, 2'b00, 2'b00);
    end
    tick();
    check_btn("rel_pulse", 2'b00, 2'b00, 2'b01, 2'b00);
    tick();
    check_btn("rel_after", 2'b00, 2'b00, 2'b00, 2'b00);

    // 7-clock press glitch is rejected.
    BTN_PAD = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_btn("glitch_in", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    BTN_PAD = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_btn("glitch_out", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Reset at debounce count 5 discards progress; full 10 edges needed afterwards.
    BTN_PAD = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_btn("mid_pre", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_btn("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    RESET = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_btn("mid_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    check_btn("mid_press", 2'b01, 2'b01, 2'b00, 2'b00);

    // Hold 30 clocks; with the long-press build a single pulse 20 clocks after level rises.
    for (int k = 1; k <= 30; k++) begin
      tick();
`ifdef BOARD_IO_LONGPRESS_EN
      exp_long = (k == 20) ? 2'b01 : 2'b00;
`else
      exp_long = 2'b00;
`endif
      check_btn("hold", 2'b01, 2'b00, 2'b00, exp_long);
    end

    // PWM, BRIGHT=1: low on pwm counts 0 and 1 of every 4.
    RESET      = 1'b1;
    BTN_PAD    = 2'b11;
    LED_IN     = 2'b01;
    LED_BRIGHT = 4'b0001;
    tick();
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_pad = ((k % 4) <= 1) ? 1'b0 : 1'b1;
      check("pwm_b1", 32'(LED_PAD), 32'({1'b1, exp_pad}));
    end
    LED_BRIGHT = 4'b0011;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check("pwm_b3", 32'(LED_PAD), 32'h2);
    end
    LED_IN = 2'b00;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check("pwm_off", 32'(LED_PAD), 32'h3);
    end

    // Blink on LED 1 at full brightness: 16 low / 16 high starting low after reset.
    RESET      = 1'b1;
    LED_IN     = 2'b10;
    LED_BLINK  = 2'b10;
    LED_BRIGHT = 4'b1100;
    tick();
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      exp_pad = ((k / 16) % 2 == 1) ? 1'b1 : 1'b0;
      check("blink", 32'(LED_PAD), 32'({exp_pad, 1'b1}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
